// File: rtl/mem_pkg.sv
// Shared constants for the paged memory mapper: I/O port decode, divMMC automap
// trap addresses, SRAM region tags and the automap state type.
package mem_pkg;

    // 0x7FFD is partially decoded: selected whenever A15=0 and A1=0
    localparam logic [15:0] P7FFD_MASK    = 16'h8002;
    localparam logic [7:0]  PE3_ADDR      = 8'hE3;

    localparam int          N_TRAPS       = 6;
    localparam logic [N_TRAPS*16-1:0] TRAP_LIST = {
        16'h0562, 16'h04C6, 16'h0066, 16'h0038, 16'h0008, 16'h0000
    };
    localparam logic [7:0]  TRAP_ROM3_HI  = 8'h3D;
    localparam logic [15:0] TRAP_OFF_BASE = 16'h1FF8;

    localparam logic        RAM_REGION    = 1'b0;
    localparam logic        DIV_REGION    = 1'b1;
    localparam logic [2:0]  BANK_4000     = 3'd5;
    localparam logic [2:0]  BANK_8000     = 3'd2;
    localparam int          MAPRAM_PAGE   = 3;

    typedef enum logic {
        AM_OFF = 1'b0,
        AM_ON  = 1'b1
    } automap_state_e;

    function automatic logic is_port_7ffd(input logic [15:0] addr);
        return (addr & P7FFD_MASK) == 16'h0000;
    endfunction

endpackage

// File: rtl/div_automap.sv
// divMMC automap state machine: M1-driven entry/exit traps with one-fetch
// deferred map/unmap, plus the immediate ROM3 0x3Dxx entry.
module div_automap
    import mem_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        m1Rd,
    input  logic [15:0] cpuA,
    input  logic        romPage,
    output logic        map
);

    automap_state_e     state_q, state_d;
    logic               pend_on_q, pend_on_d;
    logic               pend_off_q, pend_off_d;
    logic [N_TRAPS-1:0] trap_hit;
    logic               hit_entry;
    logic               hit_rom3;
    logic               hit_exit;

    genvar gi;
    generate
        for (gi = 0; gi < N_TRAPS; gi++) begin : g_trap
            assign trap_hit[gi] = (cpuA == TRAP_LIST[gi*16 +: 16]);
        end
    endgenerate

    assign hit_entry = |trap_hit;
    assign hit_rom3  = (cpuA[15:8] == TRAP_ROM3_HI) && romPage;
    assign hit_exit  = (cpuA[15:3] == TRAP_OFF_BASE[15:3]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= AM_OFF;
            pend_on_q  <= 1'b0;
            pend_off_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_on_q  <= pend_on_d;
            pend_off_q <= pend_off_d;
        end
    end

    // Pending flags from the previous fetch are consumed first; traps seen on
    // this fetch then overwrite them, and the ROM3 entry beats any exit trap.
    always_comb begin
        state_d    = state_q;
        pend_on_d  = pend_on_q;
        pend_off_d = pend_off_q;
        if (m1Rd) begin
            case (state_q)
                AM_OFF:  if (pend_on_q)  state_d = AM_ON;
                AM_ON:   if (pend_off_q) state_d = AM_OFF;
                default: state_d = AM_OFF;
            endcase
            if (pend_on_q)
                state_d = AM_ON;
            pend_on_d  = hit_entry;
            pend_off_d = hit_exit && !hit_rom3;
            if (hit_rom3)
                state_d = AM_ON;
        end
    end

    assign map = (state_q == AM_ON);

endmodule

// File: rtl/mem_mapper.sv
// Paged memory mapper for the 128K machine: 0x7FFD paging with lock, SRAM/ROM decode
// and, when MEM_MAPPER_DIVMMC_EN is defined, the divMMC 0xE3 port and automap.
module mem_mapper
    import mem_pkg::*;
#(
    parameter int RAM_AW    = 21,
    parameter int BANK_BITS = 3,
    parameter int DIV_BITS  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       cpuA,
    input  logic [7:0]        cpuDi,
    input  logic              cpuWe,
    input  logic              ioWr,
    input  logic              m1Rd,
    output logic              romSel,
    output logic              romPage,
    output logic              divRomSel,
    output logic              divMap,
    output logic              vidBank,
    output logic              ramWe,
    output logic [RAM_AW-1:0] ramA
);

    logic [7:0]           p7ffd_q, p7ffd_d;
    logic                 lock_q, lock_d;
    logic                 wr_7ffd;
    logic [4:0]           bank_full;
    logic [BANK_BITS-1:0] bank_c000;
    logic [BANK_BITS-1:0] sel_bank;
    logic [RAM_AW-1:0]    bank_addr;

    logic                 div_active;
    logic                 div_lo_ram;
    logic                 div_hi_wp;
    logic [RAM_AW-1:0]    div_addr;
    logic [RAM_AW-1:0]    mapram_addr;

    assign wr_7ffd = ioWr && is_port_7ffd(cpuA) && !lock_q;

    always_comb begin
        p7ffd_d = p7ffd_q;
        lock_d  = lock_q;
        if (wr_7ffd) begin
            p7ffd_d = cpuDi;
            lock_d  = cpuDi[5];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p7ffd_q <= 8'h00;
            lock_q  <= 1'b0;
        end else begin
            p7ffd_q <= p7ffd_d;
            lock_q  <= lock_d;
        end
    end

    assign bank_full = {p7ffd_q[7:6], p7ffd_q[2:0]};
    assign bank_c000 = bank_full[BANK_BITS-1:0];
    assign romPage   = p7ffd_q[4];
    assign vidBank   = p7ffd_q[3];

    always_comb begin
        case (cpuA[15:14])
            2'b01:   sel_bank = BANK_BITS'(BANK_4000);
            2'b10:   sel_bank = BANK_BITS'(BANK_8000);
            default: sel_bank = bank_c000;
        endcase
    end

    assign bank_addr = {RAM_REGION, (RAM_AW-1)'({sel_bank, cpuA[13:0]})};

`ifdef MEM_MAPPER_DIVMMC_EN
    logic [7:0]          div_ctrl_q, div_ctrl_d;
    logic                mapram_q, mapram_d;
    logic                wr_e3;
    logic                auto_map;
    logic                conmem;
    logic [DIV_BITS-1:0] div_page;
    logic                unused_bits;

    assign wr_e3 = ioWr && (cpuA[7:0] == PE3_ADDR);

    // MAPRAM can only be set; it is cleared by reset alone.
    always_comb begin
        div_ctrl_d = div_ctrl_q;
        mapram_d   = mapram_q;
        if (wr_e3) begin
            div_ctrl_d = cpuDi;
            mapram_d   = mapram_q | cpuDi[6];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_ctrl_q <= 8'h00;
            mapram_q   <= 1'b0;
        end else begin
            div_ctrl_q <= div_ctrl_d;
            mapram_q   <= mapram_d;
        end
    end

    div_automap u_automap (
        .clock   (clock),
        .reset   (reset),
        .m1Rd    (m1Rd),
        .cpuA    (cpuA),
        .romPage (p7ffd_q[4]),
        .map     (auto_map)
    );

    assign conmem      = div_ctrl_q[7];
    assign div_active  = auto_map | conmem;
    assign div_page    = div_ctrl_q[DIV_BITS-1:0];
    assign div_lo_ram  = mapram_q && !conmem;
    assign div_hi_wp   = div_lo_ram && (div_page == DIV_BITS'(MAPRAM_PAGE));
    assign div_addr    = {DIV_REGION, (RAM_AW-1)'({div_page, cpuA[12:0]})};
    assign mapram_addr = {DIV_REGION, (RAM_AW-1)'({DIV_BITS'(MAPRAM_PAGE), cpuA[12:0]})};
    assign divMap      = div_active;
    assign unused_bits = ^{bank_full, p7ffd_q[5], div_ctrl_q};
`else
    logic unused_bits;

    assign div_active  = 1'b0;
    assign div_lo_ram  = 1'b0;
    assign div_hi_wp   = 1'b0;
    assign div_addr    = '0;
    assign mapram_addr = '0;
    assign divMap      = 1'b0;
    assign unused_bits = ^{bank_full, p7ffd_q[5], m1Rd};
`endif

    // Lower 16K: divMMC overlay first, then the system ROM; RAM banks above.
    always_comb begin
        romSel    = 1'b0;
        divRomSel = 1'b0;
        ramWe     = cpuWe;
        ramA      = bank_addr;
        if (cpuA[15:14] == 2'b00) begin
            if (div_active && !cpuA[13]) begin
                ramWe = 1'b1;
                if (div_lo_ram)
                    ramA = mapram_addr;
                else
                    divRomSel = 1'b1;
            end else if (div_active) begin
                ramA = div_addr;
                if (div_hi_wp)
                    ramWe = 1'b1;
            end else begin
                romSel = 1'b1;
                ramWe  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_mapper.sv
// Bench for mem_mapper: directed vector table, hand-written divMMC sequences and
// random traffic checked against an arithmetic model of the memory map.
`timescale 1ns/1ps
module tb_mem_mapper;

    localparam int RAM_AW    = 21;
    localparam int BANK_BITS = 3;
    localparam int DIV_BITS  = 4;
`ifdef MEM_MAPPER_DIVMMC_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic [15:0]       cpuA;
    logic [7:0]        cpuDi;
    logic              cpuWe;
    logic              ioWr;
    logic              m1Rd;
    logic              romSel;
    logic              romPage;
    logic              divRomSel;
    logic              divMap;
    logic              vidBank;
    logic              ramWe;
    logic [RAM_AW-1:0] ramA;

    mem_mapper #(
        .RAM_AW    (RAM_AW),
        .BANK_BITS (BANK_BITS),
        .DIV_BITS  (DIV_BITS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cpuA      (cpuA),
        .cpuDi     (cpuDi),
        .cpuWe     (cpuWe),
        .ioWr      (ioWr),
        .m1Rd      (m1Rd),
        .romSel    (romSel),
        .romPage   (romPage),
        .divRomSel (divRomSel),
        .divMap    (divMap),
        .vidBank   (vidBank),
        .ramWe     (ramWe),
        .ramA      (ramA)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_p7ffd, m_divctrl;
    bit m_lock, m_mapram, m_map, m_pon, m_poff;
    int traps[6] = '{'h0000, 'h0008, 'h0038, 'h0066, 'h04C6, 'h0562};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int div_ram(input int page, input int a);
        return (1 << (RAM_AW - 1)) + page * 8192 + a % 8192;
    endfunction

    task automatic model_reset();
        m_p7ffd = 0; m_lock = 0; m_divctrl = 0; m_mapram = 0;
        m_map = 0; m_pon = 0; m_poff = 0;
    endtask

    // Expected outputs for the current inputs and model state
    task automatic check_all(input string tag);
        int  a, page, bank, e_a;
        bit  conmem, act, e_rom, e_drom, e_we, e_av;
        a      = int'(cpuA);
        conmem = DIV_EN && (m_divctrl >= 128);
        act    = DIV_EN && (m_map || conmem);
        e_rom = 0; e_drom = 0; e_we = cpuWe; e_av = 1; e_a = 0;
        if (act && a < 'h2000) begin
            e_we = 1;
            if (m_mapram && !conmem) e_a = div_ram(3, a);
            else begin e_drom = 1; e_av = 0; end
        end else if (act && a < 'h4000) begin
            page = m_divctrl % (1 << DIV_BITS);
            e_a  = div_ram(page, a);
            if (m_mapram && !conmem && page == 3) e_we = 1;
        end else if (a < 'h4000) begin
            e_rom = 1; e_we = 1; e_av = 0;
        end else begin
            if (a < 'h8000)      bank = 5;
            else if (a < 'hC000) bank = 2;
            else bank = ((m_p7ffd / 64) * 8 + m_p7ffd % 8) % (1 << BANK_BITS);
            e_a = bank * 16384 + a % 16384;
        end
        chk($sformatf("%s.romSel@%h", tag, cpuA), 32'(romSel), 32'(e_rom));
        chk($sformatf("%s.divRomSel@%h", tag, cpuA), 32'(divRomSel), 32'(e_drom));
        chk($sformatf("%s.ramWe@%h", tag, cpuA), 32'(ramWe), 32'(e_we));
        chk($sformatf("%s.divMap", tag), 32'(divMap), 32'(act));
        chk($sformatf("%s.romPage", tag), 32'(romPage), 32'((m_p7ffd / 16) % 2));
        chk($sformatf("%s.vidBank", tag), 32'(vidBank), 32'((m_p7ffd / 8) % 2));
        if (e_av) chk($sformatf("%s.ramA@%h", tag, cpuA), 32'(ramA), 32'(e_a));
    endtask

    task automatic model_clock();
        int a;
        bit old_rp;
        a      = int'(cpuA);
        old_rp = ((m_p7ffd / 16) % 2) == 1;
        if (DIV_EN && m1Rd) begin
            if (m_pon) m_map = 1;
            else if (m_poff) m_map = 0;
            m_pon = 0; m_poff = 0;
            foreach (traps[i]) if (a == traps[i]) m_pon = 1;
            if (a >= 'h1FF8 && a <= 'h1FFF) m_poff = 1;
            if (a / 256 == 'h3D && old_rp) begin m_map = 1; m_poff = 0; end
        end
        if (DIV_EN && ioWr && a % 256 == 'hE3) begin
            m_divctrl = int'(cpuDi);
            if (cpuDi[6]) m_mapram = 1;
        end
        if (ioWr && a < 'h8000 && (a / 2) % 2 == 0 && !m_lock) begin
            m_p7ffd = int'(cpuDi);
            m_lock  = cpuDi[5];
        end
    endtask

    task automatic idle();
        cpuA = 16'h0000; cpuDi = 8'h00; cpuWe = 1'b1; ioWr = 1'b0; m1Rd = 1'b0;
    endtask

    // Called just after a rising edge; leaves time just after the next rising edge.
    task automatic do_reset();
        idle();
        reset = 1'b0;
        #2;
        model_reset();
        check_all("rst");
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic step(input int a, input int di, input bit we, input bit iow,
                        input bit m1, input string tag);
        cpuA = 16'(a); cpuDi = 8'(di); cpuWe = we; ioWr = iow; m1Rd = m1;
        @(negedge clock);
        check_all(tag);
        @(posedge clock);
        model_clock();
        #1;
    endtask

    typedef struct {
        bit          rst;
        logic [15:0] a;
        logic [7:0]  di;
        bit          we;
        bit          iow;
        bit          rom;
        bit          rpage;
        bit          vid;
        bit          rwe;
        bit          a_chk;
        logic [31:0] addr;
    } vec_t;

    vec_t vt[14];

    initial begin
        reset = 1'b0;
        idle();
        #1;

        //        rst  a         di     we iow rom rp vid rwe chk addr
        vt[0]  = '{1, 16'h0000, 8'h00, 1, 0,  1,  0, 0,  1,  0, 32'h00000};
        vt[1]  = '{0, 16'h7FFD, 8'h07, 1, 1,  0,  0, 0,  1,  1, 32'h17FFD};
        vt[2]  = '{0, 16'hC000, 8'h00, 1, 0,  0,  0, 0,  1,  1, 32'h1C000};
        vt[3]  = '{0, 16'h7FFD, 8'h20, 1, 1,  0,  0, 0,  1,  1, 32'h17FFD};
        vt[4]  = '{0, 16'h7FFD, 8'h01, 1, 1,  0,  0, 0,  1,  1, 32'h17FFD};
        vt[5]  = '{0, 16'hC000, 8'h00, 1, 0,  0,  0, 0,  1,  1, 32'h00000};
        vt[6]  = '{0, 16'h8000, 8'h00, 0, 0,  0,  0, 0,  0,  1, 32'h08000};
        vt[7]  = '{0, 16'h4123, 8'h00, 0, 0,  0,  0, 0,  0,  1, 32'h14123};
        vt[8]  = '{1, 16'h7FFD, 8'h18, 1, 1,  0,  0, 0,  1,  1, 32'h17FFD};
        vt[9]  = '{0, 16'h0000, 8'h00, 1, 0,  1,  1, 1,  1,  0, 32'h00000};
        vt[10] = '{0, 16'h1000, 8'h00, 0, 0,  1,  1, 1,  1,  0, 32'h00000};
        vt[11] = '{0, 16'hFFFF, 8'h00, 1, 0,  0,  1, 1,  1,  1, 32'h03FFF};
        vt[12] = '{0, 16'h7FFD, 8'h03, 1, 1,  0,  1, 1,  1,  1, 32'h17FFD};
        vt[13] = '{0, 16'hC000, 8'h00, 0, 0,  0,  0, 0,  0,  1, 32'h0C000};

        for (int i = 0; i < 14; i++) begin
            if (vt[i].rst) do_reset();
            cpuA = vt[i].a; cpuDi = vt[i].di; cpuWe = vt[i].we; ioWr = vt[i].iow; m1Rd = 1'b0;
            @(negedge clock);
            $display("vec %0d a=%h di=%h we=%0d iow=%0d -> romSel=%0d romPage=%0d vidBank=%0d ramWe=%0d ramA=%h",
                     i, vt[i].a, vt[i].di, vt[i].we, vt[i].iow, romSel, romPage, vidBank, ramWe, ramA);
            chk($sformatf("vec%0d.romSel", i), 32'(romSel), 32'(vt[i].rom));
            chk($sformatf("vec%0d.romPage", i), 32'(romPage), 32'(vt[i].rpage));
            chk($sformatf("vec%0d.vidBank", i), 32'(vidBank), 32'(vt[i].vid));
            chk($sformatf("vec%0d.ramWe", i), 32'(ramWe), 32'(vt[i].rwe));
            chk($sformatf("vec%0d.divMap", i), 32'(divMap), 32'd0);
            chk($sformatf("vec%0d.divRomSel", i), 32'(divRomSel), 32'd0);
            if (vt[i].a_chk) chk($sformatf("vec%0d.ramA", i), 32'(ramA), vt[i].addr);
            @(posedge clock);
            model_clock();
            #1;
        end

        do_reset();
`ifdef MEM_MAPPER_DIVMMC_EN
        step('h0038, 0, 1, 0, 1, "m1_0038");
        chk("seq.pending_only", 32'(divMap), 32'd0);
        step('h0039, 0, 1, 0, 1, "m1_0039");
        chk("seq.mapped_after_0039", 32'(divMap), 32'd1);
        step('h0100, 0, 1, 0, 0, "rd_0100");
        chk("seq.divrom_0100", 32'(divRomSel), 32'd1);
        step('h1FF9, 0, 1, 0, 1, "m1_1FF9");
        chk("seq.still_mapped", 32'(divMap), 32'd1);
        step('h0200, 0, 1, 0, 1, "m1_0200");
        chk("seq.unmapped", 32'(divMap), 32'd0);
        step('h7FFD, 'h10, 1, 1, 0, "rompage1");
        step('h3D00, 0, 1, 0, 1, "m1_3D00");
        chk("seq.rom3_immediate", 32'(divMap), 32'd1);
        step('h00E3, 'h43, 1, 1, 0, "e3_43");
        step('h0000, 0, 1, 0, 0, "rd_0000_mapram");
        chk("seq.mapram_page3", 32'(ramA), 32'h106000);
        step('h2000, 0, 0, 0, 0, "wr_2000_wp");
        chk("seq.page3_write_blocked", 32'(ramWe), 32'd1);
        step('h00E3, 'h00, 1, 1, 0, "e3_00");
        step('h0010, 0, 1, 0, 0, "rd_0010_sticky");
        chk("seq.mapram_sticky", 32'(ramA), 32'h106010);
        step('h1FF8, 0, 1, 0, 1, "m1_1FF8");
        step('h0500, 0, 1, 0, 1, "m1_0500");
        chk("seq.unmapped2", 32'(divMap), 32'd0);
        step('h00E3, 'h85, 1, 1, 0, "e3_85");
        chk("seq.conmem_map", 32'(divMap), 32'd1);
        step('h2000, 0, 0, 0, 0, "wr_2000_conmem");
        chk("seq.conmem_page5_addr", 32'(ramA), 32'h10A000);
        chk("seq.conmem_page5_we", 32'(ramWe), 32'd0);
`else
        step('h00E3, 'h85, 1, 1, 0, "e3_ignored");
        chk("seq.no_divmap", 32'(divMap), 32'd0);
        step('h0000, 0, 1, 0, 0, "rd_0000_rom");
        chk("seq.rom_at_0000", 32'(romSel), 32'd1);
        step('h0038, 0, 1, 0, 1, "m1_0038");
        step('h0039, 0, 1, 0, 1, "m1_0039");
        chk("seq.no_automap", 32'(divMap), 32'd0);
`endif

        for (int n = 0; n < 600; n++) begin
            int  kind, a, di;
            bit  iow, m1, we;
            kind = int'($urandom_range(0, 11));
            a    = int'($urandom_range(0, 65535));
            di   = int'($urandom_range(0, 255));
            we   = 1'($urandom_range(0, 1));
            iow  = 0;
            m1   = 0;
            if ($urandom_range(0, 7) != 0) di = di & 'hDF;
            case (kind)
                0, 1: begin a = traps[$urandom_range(0, 5)]; m1 = 1; end
                2:    begin a = 'h3D00 + int'($urandom_range(0, 255)); m1 = 1; end
                3:    begin a = 'h1FF8 + int'($urandom_range(0, 7)); m1 = 1; end
                4:    begin a = 'h7FFD; iow = 1; end
                5:    begin a = int'($urandom_range(0, 255)) * 256 + 'hE3; iow = 1; end
                6:    m1 = 1;
                7:    a = int'($urandom_range(0, 'h3FFF));
                default: ;
            endcase
            if (iow || m1) we = 1;
            if ($urandom_range(0, 59) == 0) do_reset();
            step(a, di, we, iow, m1, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
